frame_write_arbiter: RTL
========================

# frame_write_arbiter

Owns port A of the 160x120 one-bit frame buffer and shares it between two requesters: CPU single-pixel writes (bus addresses 0xB0–0xB2) and a hardware rectangle-fill engine (0xB4–0xB7). Sits between the system bus and the frame buffer's A port, replacing direct bus-decoded writes. Lets software clear the screen or draw a box with one command instead of W*H bus writes, and exposes BUSY and DONE to the CPU.

## Interface
- FB_W, 160, visible columns; X coordinate width is 8 bits.
- FB_H, 120, visible rows; Y coordinate width is 7 bits.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  8  bus address.
- BUS_DATA_IN  in  8  bus write data.
- BUS_WE  in  1  bus write strobe; one cycle per write.
- BUS_DATA_OUT  out  8  read data for 0xB7; 0 otherwise.
- BUS_DATA_OE  out  1  high when BUS_ADDR==0xB7 and !BUS_WE; the top level uses it to drive the tristate bus.
- FB_ADDR  out  15  {Y[6:0],X[7:0]} to frame buffer A_ADDR.
- FB_DATA  out  1  pixel value to A_DATA_IN.
- FB_WE  out  1  write enable to A_WE.
- IRQ_DONE  out  1  one-cycle pulse when a fill completes or aborts.

## Operation
- Bus registers (written when BUS_WE and address match):
  - 0xB0: X0[7:0].
  - 0xB1: Y0[6:0].
  - 0xB2: single-pixel request; value is data[0], address is {Y0,X0}.
  - 0xB4: WIDTH[7:0].
  - 0xB5: HEIGHT[6:0].
  - 0xB6: command. Bit0 is the fill colour. Bit6 starts a fill. Bit7 aborts.
  - 0xB7 (read): {BUSY, DONE_STICKY, 6'b0}. DONE_STICKY clears on the read.
- FSM states: IDLE, FILL, FINISH.
- IDLE -> FILL:
  - Trigger is a start write while idle with WIDTH!=0 and HEIGHT!=0.
  - Latches X0/Y0/W/H/colour into working registers.
  - Later writes to 0xB0–0xB5 do not affect the running fill.
- IDLE -> FINISH: start with WIDTH==0 or HEIGHT==0. Performs no writes.
- FILL walk:
  - Raster order: x from X0 to X0+W-1, then y+1.
  - Exits to FINISH after pixel (X0+W-1, Y0+H-1).
- FILL -> FINISH on abort. The in-flight write completes; nothing further is written.
- FINISH -> IDLE after one cycle. In that cycle: IRQ_DONE=1, DONE_STICKY<=1.
- A start write while BUSY (FILL or FINISH) is ignored. Abort together with start in the same write means abort.
- Arbitration (fixed priority):
  - A pending bus pixel request beats the fill engine.
  - The fill holds its position that cycle and resumes next cycle.
  - There is no starvation limit; the CPU is the master.
- Coordinate arithmetic:
  - X is 8-bit and Y is 7-bit, modulo arithmetic.
  - Overflow wraps unless clipping is compiled in (see Configuration).

## Timing
- Reset values:
  - FB_WE=0, FB_ADDR=0, FB_DATA=0, IRQ_DONE=0, BUS_DATA_OUT=0, BUS_DATA_OE=0.
  - All registers 0; FSM in IDLE.
  - Reset mid-fill aborts immediately, with no IRQ.
- Outputs FB_* are registered.
- Bus pixel write: 0xB2 write in cycle n gives FB_WE=1 in cycle n+1 with the address and data captured in cycle n.
- Fill: start write in cycle n gives the first FB_WE in cycle n+1, then one pixel per cycle.
- Uncontended fill: last write in cycle n+W*H, IRQ_DONE in cycle n+W*H+1.
- Each bus pixel write during a fill adds exactly one cycle.
- BUSY=1 from cycle n+1 through the FINISH cycle inclusive.
- BUS_DATA_OUT and BUS_DATA_OE are combinational from BUS_ADDR and BUS_WE.

## Configuration
- FRAME_WRITE_CLIP_EN defined:
  - Fill pixels with x>=FB_W or y>=FB_H are skipped. FB_WE stays low for them, and the walker still advances one per cycle, so timing is unchanged.
  - Single-pixel writes outside the screen are dropped.
- FRAME_WRITE_CLIP_EN undefined: coordinates wrap modulo 256/128 and every pixel is written.

## Structure
- Shared package fb_pkg holds:
  - FB_W, FB_H, and the X/Y widths.
  - Bus address constants 0xB0–0xB7.
  - The command bit positions.
  - The FSM state enum.
- One sub-module, fill_walker:
  - Loads X0/Y0/W/H and steps on an advance input.
  - Outputs the current x/y and a last flag.
- The arbitration FSM stays in the top module.

## Test plan
- Reset, then write X0=5, Y0=7, then 0xB2 data=1 -> one cycle later FB_WE=1, FB_ADDR=0x0705, FB_DATA=1; no further writes.
- WIDTH=3, HEIGHT=2, X0=10, Y0=20, start with colour 1 -> 6 consecutive writes: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21). IRQ_DONE one cycle after the last write. 0xB7 reads 0x40, then 0x00 on a second read.
- During a 4x1 fill, issue a 0xB2 write at the second fill cycle -> the bus pixel is written that cycle, the fill resumes at the same x, and IRQ_DONE is delayed by exactly 1 cycle.
- WIDTH=0 start -> no FB_WE; IRQ_DONE one cycle after start; BUSY low again 2 cycles after the start write.
- 160x120 fill, abort after 100 writes -> no writes after the abort cycle plus one, IRQ_DONE pulses; a start written during the fill is ignored.
- X0=158, WIDTH=4, HEIGHT=1 -> with CLIP_EN, 2 writes (x=158,159) and 4 cycles; without it, 4 writes (x=158,159,160,161).

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write path: screen geometry,
// bus register map, command bits and the fill arbiter state encoding.
package fb_pkg;

  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int FB_ADDR_W = X_W + Y_W;

  localparam logic [X_W-1:0] FB_W = 8'd160;
  localparam logic [Y_W-1:0] FB_H = 7'd120;

  localparam logic [7:0] ADDR_X0     = 8'hB0;
  localparam logic [7:0] ADDR_Y0     = 8'hB1;
  localparam logic [7:0] ADDR_PIXEL  = 8'hB2;
  localparam logic [7:0] ADDR_WIDTH  = 8'hB4;
  localparam logic [7:0] ADDR_HEIGHT = 8'hB5;
  localparam logic [7:0] ADDR_CMD    = 8'hB6;
  localparam logic [7:0] ADDR_STATUS = 8'hB7;

  localparam int CMD_COLOUR_BIT = 0;
  localparam int CMD_START_BIT  = 6;
  localparam int CMD_ABORT_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_FINISH = 2'd2
  } fill_state_e;

  // True when a coordinate lies inside the visible screen area.
  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < FB_W) && (y < FB_H);
  endfunction

endpackage

// File: rtl/fill_walker.sv
// Raster walker for the rectangle fill: holds the working copy of the
// rectangle origin and size and steps through it one pixel per advance.
module fill_walker
  import fb_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic           advance_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] width_i,
  input  logic [Y_W-1:0] height_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  logic [X_W-1:0] x_q, x_d, x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [Y_W-1:0] y_q, y_d, h_q, h_d, row_q, row_d;
  logic [X_W-1:0] baseX, baseCol;
  logic [Y_W-1:0] baseY, baseRow;

  // Load takes the new rectangle as the starting point; advance then steps once
  // from whichever position is current, so load+advance lands on pixel 1.
  always_comb begin
    x0_d    = x0_q;
    w_d     = w_q;
    h_d     = h_q;
    baseX   = x_q;
    baseY   = y_q;
    baseCol = col_q;
    baseRow = row_q;
    if (load_i) begin
      x0_d    = x0_i;
      w_d     = width_i;
      h_d     = height_i;
      baseX   = x0_i;
      baseY   = y0_i;
      baseCol = '0;
      baseRow = '0;
    end
    x_d   = baseX;
    y_d   = baseY;
    col_d = baseCol;
    row_d = baseRow;
    if (advance_i) begin
      if (baseCol == w_d - 8'd1) begin
        col_d = '0;
        x_d   = x0_d;
        row_d = baseRow + 7'd1;
        y_d   = baseY + 7'd1;
      end else begin
        col_d = baseCol + 8'd1;
        x_d   = baseX + 8'd1;
      end
    end
  end

  // Walker position and rectangle working registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      x0_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      x0_q  <= x0_d;
      w_q   <= w_d;
      h_q   <= h_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (col_q == w_q - 8'd1) && (row_q == h_q - 7'd1);

endmodule

// File: rtl/frame_write_arbiter.sv
// Owns frame buffer port A and shares it between CPU single-pixel writes and
// the rectangle fill engine; the CPU always wins a contested cycle.
// Build option: define FRAME_WRITE_CLIP_EN to suppress off-screen writes
// instead of letting coordinates wrap.
module frame_write_arbiter
  import fb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           bus_addr_i,
  input  logic [7:0]           bus_data_i,
  input  logic                 bus_we_i,
  output logic [7:0]           bus_data_o,
  output logic                 bus_data_oe_o,
  output logic [FB_ADDR_W-1:0] fb_addr_o,
  output logic                 fb_data_o,
  output logic                 fb_we_o,
  output logic                 irq_done_o
);

  fill_state_e state_q, state_d;

  logic [X_W-1:0]       x0_q, width_q;
  logic [Y_W-1:0]       y0_q, height_q;
  logic                 colour_q, colour_d;
  logic                 lastEmitted_q, lastEmitted_d;
  logic                 done_q, done_d;
  logic                 fbWe_q, fbWe_d;
  logic [FB_ADDR_W-1:0] fbAddr_q, fbAddr_d;
  logic                 fbData_q, fbData_d;

  logic wrX0, wrY0, wrPix, wrWidth, wrHeight, wrCmd, rdStatus;
  logic startReq, abortReq, busy;
  logic walkLoad, walkAdvance, walkLast;
  logic [X_W-1:0] walkX;
  logic [Y_W-1:0] walkY;
  logic originVisible, walkVisible;

  assign wrX0     = bus_we_i && (bus_addr_i == ADDR_X0);
  assign wrY0     = bus_we_i && (bus_addr_i == ADDR_Y0);
  assign wrPix    = bus_we_i && (bus_addr_i == ADDR_PIXEL);
  assign wrWidth  = bus_we_i && (bus_addr_i == ADDR_WIDTH);
  assign wrHeight = bus_we_i && (bus_addr_i == ADDR_HEIGHT);
  assign wrCmd    = bus_we_i && (bus_addr_i == ADDR_CMD);
  assign rdStatus = !bus_we_i && (bus_addr_i == ADDR_STATUS);

  assign abortReq = wrCmd && bus_data_i[CMD_ABORT_BIT];
  assign startReq = wrCmd && bus_data_i[CMD_START_BIT] && !bus_data_i[CMD_ABORT_BIT];
  assign busy     = (state_q != ST_IDLE);

`ifdef FRAME_WRITE_CLIP_EN
  assign originVisible = on_screen(x0_q, y0_q);
  assign walkVisible   = on_screen(walkX, walkY);
`else
  assign originVisible = 1'b1;
  assign walkVisible   = 1'b1;
`endif

  fill_walker u_walker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (walkLoad),
    .advance_i (walkAdvance),
    .x0_i      (x0_q),
    .y0_i      (y0_q),
    .width_i   (width_q),
    .height_i  (height_q),
    .x_o       (walkX),
    .y_o       (walkY),
    .last_o    (walkLast)
  );

  // CPU-visible parameter registers; the fill copies these at start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x0_q     <= '0;
      y0_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else begin
      if (wrX0)     x0_q     <= bus_data_i;
      if (wrY0)     y0_q     <= bus_data_i[Y_W-1:0];
      if (wrWidth)  width_q  <= bus_data_i;
      if (wrHeight) height_q <= bus_data_i[Y_W-1:0];
    end
  end

  // Arbitration and fill sequencing; the first fill pixel is issued on the
  // start edge itself so it appears on the port the very next cycle.
  always_comb begin
    state_d       = state_q;
    colour_d      = colour_q;
    lastEmitted_d = lastEmitted_q;
    done_d        = done_q;
    fbWe_d        = 1'b0;
    fbAddr_d      = fbAddr_q;
    fbData_d      = fbData_q;
    walkLoad      = 1'b0;
    walkAdvance   = 1'b0;

    if (rdStatus) done_d = 1'b0;

    if (wrPix && originVisible) begin
      fbWe_d   = 1'b1;
      fbAddr_d = {y0_q, x0_q};
      fbData_d = bus_data_i[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (startReq) begin
          if ((width_q != '0) && (height_q != '0)) begin
            state_d       = ST_FILL;
            walkLoad      = 1'b1;
            walkAdvance   = 1'b1;
            colour_d      = bus_data_i[CMD_COLOUR_BIT];
            lastEmitted_d = (width_q == 8'd1) && (height_q == 7'd1);
            fbWe_d        = originVisible;
            fbAddr_d      = {y0_q, x0_q};
            fbData_d      = bus_data_i[CMD_COLOUR_BIT];
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FILL: begin
        if (abortReq || lastEmitted_q) begin
          state_d = ST_FINISH;
        end else if (!wrPix) begin
          fbWe_d        = walkVisible;
          fbAddr_d      = {walkY, walkX};
          fbData_d      = colour_q;
          walkAdvance   = 1'b1;
          lastEmitted_d = walkLast;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered frame buffer port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      colour_q      <= 1'b0;
      lastEmitted_q <= 1'b0;
      done_q        <= 1'b0;
      fbWe_q        <= 1'b0;
      fbAddr_q      <= '0;
      fbData_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      colour_q      <= colour_d;
      lastEmitted_q <= lastEmitted_d;
      done_q        <= done_d;
      fbWe_q        <= fbWe_d;
      fbAddr_q      <= fbAddr_d;
      fbData_q      <= fbData_d;
    end
  end

  assign fb_we_o       = fbWe_q;
  assign fb_addr_o     = fbAddr_q;
  assign fb_data_o     = fbData_q;
  assign irq_done_o    = (state_q == ST_FINISH);
  assign bus_data_oe_o = rdStatus;
  assign bus_data_o    = rdStatus ? {busy, done_q, 6'b0} : 8'h00;

endmodule
